// File: rtl/tff_mod_counter.sv
// ----------------------------------------------------------------------------
// tff_mod_counter
//
// Synchronous modulo-MOD up/down counter placed directly upstream of the
// T flip-flop divider chain. The next count is formed with toggle-enable
// logic per bit (bit i toggles when every lower bit is 1 counting up, or 0
// counting down). A wrap correction replaces the T result at terminal count
// so the sequence stays inside 0..MOD-1.
//
// A registered toggle_out flips on every terminal event and drives the t
// input of the next divider stage. In continuous counting it therefore has
// a period of 2*MOD clocks. In one-shot mode the counter wraps once more and
// then parks in DONE until a parallel load restarts it.
//
// Parameters: WIDTH sets the counter width in bits; the modulus parameter
// must satisfy 2 <= modulus <= 2**WIDTH, and the count runs from zero up to
// one less than the modulus.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   en          count enable (ignored while in DONE)
//   up          direction: 1 = up, 0 = down
//   load        synchronous parallel load of din (priority over en)
//   din         load value, saturated to MOD-1 when out of range
//   oneshot     1 = halt in DONE after the terminal wrap, 0 = wrap forever
//   count       registered count
//   tc          combinational terminal-count strobe
//   toggle_out  registered, flips on every terminal event
//   done        registered, high while parked in DONE
// ----------------------------------------------------------------------------
module tff_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             toggle_out,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  // One extra bit so MOD = 2**WIDTH can still be compared against din.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             toggle_q, toggle_d;

  logic [WIDTH-1:0] t_vec;      // per-bit toggle enables
  logic [WIDTH-1:0] count_t;    // T-style next count with wrap correction
  logic [WIDTH-1:0] load_val;   // din saturated into range
  logic             terminal;

  // --------------------------------------------------------------------------
  // Toggle-enable generation: carry an "all lower bits one/zero" flag up the
  // word, exactly as a ripple of T flip-flop stages would.
  // --------------------------------------------------------------------------
  always_comb begin
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    t_vec    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_vec[i] = en & (up ? all_one : all_zero);
      all_one  = all_one & count_q[i];
      all_zero = all_zero & ~count_q[i];
    end
  end

  assign terminal = up ? (count_q == MAX_CNT) : (count_q == '0);

  // At terminal the raw T result would run past MOD-1 (up) or underflow to
  // all ones (down); substitute the modular wrap value instead.
  assign count_t  = terminal ? (up ? '0 : MAX_CNT) : (count_q ^ t_vec);

  assign load_val = ({1'b0, din} >= MOD_EXT) ? MAX_CNT : din;

  assign tc = en & ~load & (state_q == RUN) & terminal;

  // --------------------------------------------------------------------------
  // Next-state logic. Priority: load over counting; DONE ignores en.
  // --------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    toggle_d = toggle_q;

    if (load) begin
      count_d = load_val;
      state_d = RUN;
    end else if (en && (state_q == RUN)) begin
      count_d = count_t;
      if (tc) begin
        toggle_d = ~toggle_q;
        if (oneshot) begin
          state_d = DONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      count_q  <= '0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      toggle_q <= toggle_d;
    end
  end

  assign count      = count_q;
  assign toggle_out = toggle_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_tff_mod_counter.sv
// ----------------------------------------------------------------------------
// Testbench for tff_mod_counter (WIDTH=4, MOD=10). Directed scenarios plus a
// randomized phase, all compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_tff_mod_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, up, load, oneshot;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic             tc, toggle_out, done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_count;
  int m_tog;
  int m_done;

  tff_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up         (up),
    .load       (load),
    .din        (din),
    .oneshot    (oneshot),
    .count      (count),
    .tc         (tc),
    .toggle_out (toggle_out),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_tc();
    int term;
    term = up ? (m_count == MOD - 1) : (m_count == 0);
    return (en && !load && !m_done && term) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_tog   = 0;
    m_done  = 0;
  endtask

  // One clock edge of the modelled behaviour, using the inputs present now.
  task automatic model_edge();
    int t;
    t = model_tc();
    if (load) begin
      m_count = (int'(din) >= MOD) ? MOD - 1 : int'(din);
      m_done  = 0;
    end else if (en && !m_done) begin
      m_count = up ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
      if (t != 0) begin
        m_tog = 1 - m_tog;
        if (oneshot) m_done = 1;
      end
    end
  endtask

  // Drive inputs, check tc before the edge, clock once, check registers.
  task automatic cycle(input logic i_en, input logic i_up, input logic i_load,
                       input int i_din, input logic i_oneshot);
    en      = i_en;
    up      = i_up;
    load    = i_load;
    din     = WIDTH'(i_din);
    oneshot = i_oneshot;
    #1;
    check("tc", int'(tc), model_tc());
    @(posedge clk);
    model_edge();
    #1;
    check("count", int'(count), m_count);
    check("toggle_out", int'(toggle_out), m_tog);
    check("done", int'(done), m_done);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0; oneshot = 1'b0;
    model_reset();
    #12;
    check("rst_count", int'(count), 0);
    check("rst_toggle", int'(toggle_out), 0);
    check("rst_done", int'(done), 0);
    check("rst_tc", int'(tc), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Continuous up counting from reset
    for (int i = 0; i < 25; i++) cycle(1, 1, 0, 0, 0);
    check("cont_final_count", int'(count), 5);
    check("cont_final_toggle", int'(toggle_out), 0);

    // Down wrap from 2
    cycle(0, 0, 1, 2, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    check("down_final_count", int'(count), 8);

    // Load priority and saturation
    cycle(1, 1, 1, 4, 0);
    check("load4", int'(count), 4);
    cycle(0, 1, 1, 13, 0);
    check("load_sat", int'(count), MOD - 1);
    cycle(1, 1, 1, 1, 0);          // load while at terminal: tc must stay low
    check("load_at_tc", int'(count), 1);

    // One-shot run to DONE, then stay frozen, then restart by load
    cycle(0, 1, 1, 0, 1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 1);
    check("os_done", int'(done), 1);
    check("os_count", int'(count), 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 1, 3, 1);
    check("os_reload_done", int'(done), 0);
    check("os_reload_count", int'(count), 3);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);

    // Hold with en=0, then flip direction
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    check("hold_count", int'(count), 5);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("dir_flip_count", int'(count), 3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
            logic'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset mid-count with toggle_out set
    if (m_tog == 0) begin
      cycle(0, 1, 1, MOD - 1, 0);
      cycle(1, 1, 0, 0, 0);
    end
    cycle(0, 1, 1, 7, 1);
    check("pre_rst_count", int'(count), 7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_toggle", int'(toggle_out), 0);
    check("async_rst_done", int'(done), 0);
    #1 rst = 1'b0;
    model_reset();
    cycle(1, 1, 0, 0, 0);
    check("post_rst_count", int'(count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
